// File: rtl/mips_cpu.sv
// mips_cpu: 5-stage in-order MIPS-subset pipeline (IF ID EX MEM WB) with branches resolved in ID.
// Macro MIPS_CPU_FORWARD_EN enables EX/ID forwarding; without it, consumers stall until the producer reaches WB.
module mips_cpu #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] ins_i,
  input  logic [WIDTH-1:0] data_from_mem_i,
  output logic [WIDTH-1:0] pc_o,
  output logic [1:0]       MEM_ctrl_o,
  output logic [WIDTH-1:0] mem_write_addr_o,
  output logic [WIDTH-1:0] mem_write_data_o
);

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_op_t;

  typedef struct packed {
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    alu_imm;
    alu_op_t alu_op;
  } ctrl_t;

  typedef struct packed {
    ctrl_t            ctrl;
`ifdef MIPS_CPU_FORWARD_EN
    logic [4:0]       rs;
    logic [4:0]       rt;
`endif
    logic [4:0]       dest;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic [WIDTH-1:0] imm;
  } idex_t;

  typedef struct packed {
    logic             reg_write;
    logic             mem_read;
    logic             mem_write;
    logic [4:0]       dest;
    logic [WIDTH-1:0] alu;
    logic [WIDTH-1:0] st_data;
  } exmem_t;

  typedef struct packed {
    logic             reg_write;
    logic             mem_read;
    logic [4:0]       dest;
    logic [WIDTH-1:0] alu;
    logic [WIDTH-1:0] load;
  } memwb_t;

  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] ifid_ins;
  logic [WIDTH-1:0] ifid_pc4;
  idex_t            idex;
  exmem_t           exmem;
  memwb_t           memwb;
  logic [WIDTH-1:0] regs [32];

  // ---------------- ID: decode ----------------
  logic [5:0]       op;
  logic [5:0]       funct;
  logic [4:0]       rs;
  logic [4:0]       rt;
  logic [4:0]       rd;
  logic [4:0]       shamt;
  logic [WIDTH-1:0] imm_ext;

  assign op      = ifid_ins[31:26];
  assign rs      = ifid_ins[25:21];
  assign rt      = ifid_ins[20:16];
  assign rd      = ifid_ins[15:11];
  assign shamt   = ifid_ins[10:6];
  assign funct   = ifid_ins[5:0];
  assign imm_ext = {{(WIDTH-16){ifid_ins[15]}}, ifid_ins[15:0]};

  ctrl_t      id_ctrl;
  logic [4:0] id_dest;
  logic       use_rs;
  logic       use_rt;
  logic       is_beq;
  logic       is_j;

  // R-type encodings with a non-zero shamt are reserved and fall through as NOPs
  always_comb begin
    id_ctrl = '0;
    id_dest = rt;
    use_rs  = 1'b0;
    use_rt  = 1'b0;
    is_beq  = 1'b0;
    is_j    = 1'b0;
    case (op)
      OP_R: begin
        id_dest = rd;
        if (shamt == 5'd0) begin
          case (funct)
            FN_ADD:  id_ctrl.alu_op = ALU_ADD;
            FN_SUB:  id_ctrl.alu_op = ALU_SUB;
            FN_AND:  id_ctrl.alu_op = ALU_AND;
            FN_OR:   id_ctrl.alu_op = ALU_OR;
            FN_SLT:  id_ctrl.alu_op = ALU_SLT;
            default: id_ctrl.alu_op = ALU_ADD;
          endcase
          if (funct == FN_ADD || funct == FN_SUB || funct == FN_AND ||
              funct == FN_OR  || funct == FN_SLT) begin
            id_ctrl.reg_write = 1'b1;
            use_rs            = 1'b1;
            use_rt            = 1'b1;
          end
        end
      end
      OP_ADDI: begin
        id_ctrl.reg_write = 1'b1;
        id_ctrl.alu_imm   = 1'b1;
        use_rs            = 1'b1;
      end
      OP_LW: begin
        id_ctrl.reg_write = 1'b1;
        id_ctrl.mem_read  = 1'b1;
        id_ctrl.alu_imm   = 1'b1;
        use_rs            = 1'b1;
      end
      OP_SW: begin
        id_ctrl.mem_write = 1'b1;
        id_ctrl.alu_imm   = 1'b1;
        use_rs            = 1'b1;
        use_rt            = 1'b1;
      end
      OP_BEQ: begin
        is_beq = 1'b1;
        use_rs = 1'b1;
        use_rt = 1'b1;
      end
      OP_J:    is_j = 1'b1;
      default: ;
    endcase
  end

  // ---------------- ID: register read with WB write-through ----------------
  logic             wb_we;
  logic [WIDTH-1:0] wb_val;
  logic [WIDTH-1:0] rf_rs;
  logic [WIDTH-1:0] rf_rt;

  assign wb_we  = memwb.reg_write && (memwb.dest != 5'd0);
  assign wb_val = memwb.mem_read ? memwb.load : memwb.alu;
  assign rf_rs  = (wb_we && memwb.dest == rs) ? wb_val : regs[rs];
  assign rf_rt  = (wb_we && memwb.dest == rt) ? wb_val : regs[rt];

  // ---------------- ID: hazard detection ----------------
  logic ex_hit_rs;
  logic ex_hit_rt;
  logic mem_hit_rs;
  logic mem_hit_rt;
  logic stall;

  assign ex_hit_rs  = idex.ctrl.reg_write && idex.dest != 5'd0 && use_rs && idex.dest == rs;
  assign ex_hit_rt  = idex.ctrl.reg_write && idex.dest != 5'd0 && use_rt && idex.dest == rt;
  assign mem_hit_rs = exmem.reg_write && exmem.dest != 5'd0 && use_rs && exmem.dest == rs;
  assign mem_hit_rt = exmem.reg_write && exmem.dest != 5'd0 && use_rt && exmem.dest == rt;

`ifdef MIPS_CPU_FORWARD_EN
  // Load-use, branch on an EX producer, and branch on a load still in MEM
  assign stall = (idex.ctrl.mem_read && (ex_hit_rs || ex_hit_rt)) ||
                 (is_beq && (ex_hit_rs || ex_hit_rt)) ||
                 (is_beq && exmem.mem_read && (mem_hit_rs || mem_hit_rt));
`else
  assign stall = ex_hit_rs || ex_hit_rt || mem_hit_rs || mem_hit_rt;
`endif

  // ---------------- ID: branch resolution ----------------
  logic [WIDTH-1:0] cmp_a;
  logic [WIDTH-1:0] cmp_b;
  logic             take;
  logic [WIDTH-1:0] target;

`ifdef MIPS_CPU_FORWARD_EN
  assign cmp_a = mem_hit_rs ? exmem.alu : rf_rs;
  assign cmp_b = mem_hit_rt ? exmem.alu : rf_rt;
`else
  assign cmp_a = rf_rs;
  assign cmp_b = rf_rt;
`endif

  assign take   = !stall && (is_j || (is_beq && cmp_a == cmp_b));
  assign target = is_j ? {ifid_pc4[WIDTH-1:28], ifid_ins[25:0], 2'b00}
                       : ifid_pc4 + (imm_ext << 2);

  idex_t id_next;

  always_comb begin
    id_next        = '0;
    id_next.ctrl   = id_ctrl;
`ifdef MIPS_CPU_FORWARD_EN
    id_next.rs     = rs;
    id_next.rt     = rt;
`endif
    id_next.dest   = id_dest;
    id_next.rs_val = rf_rs;
    id_next.rt_val = rf_rt;
    id_next.imm    = imm_ext;
  end

  // ---------------- EX: operand forwarding and ALU ----------------
  logic [WIDTH-1:0] fwd_a;
  logic [WIDTH-1:0] fwd_b;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_res;

`ifdef MIPS_CPU_FORWARD_EN
  always_comb begin
    fwd_a = idex.rs_val;
    fwd_b = idex.rt_val;
    if (exmem.reg_write && exmem.dest != 5'd0 && exmem.dest == idex.rs)
      fwd_a = exmem.alu;
    else if (wb_we && memwb.dest == idex.rs)
      fwd_a = wb_val;
    if (exmem.reg_write && exmem.dest != 5'd0 && exmem.dest == idex.rt)
      fwd_b = exmem.alu;
    else if (wb_we && memwb.dest == idex.rt)
      fwd_b = wb_val;
  end
`else
  assign fwd_a = idex.rs_val;
  assign fwd_b = idex.rt_val;
`endif

  always_comb begin
    alu_b   = idex.ctrl.alu_imm ? idex.imm : fwd_b;
    alu_res = fwd_a + alu_b;
    case (idex.ctrl.alu_op)
      ALU_SUB: alu_res = fwd_a - alu_b;
      ALU_AND: alu_res = fwd_a & alu_b;
      ALU_OR:  alu_res = fwd_a | alu_b;
      ALU_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(fwd_a) < $signed(alu_b))};
      default: alu_res = fwd_a + alu_b;
    endcase
  end

  // ---------------- pipeline registers ----------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc       <= '0;
      ifid_ins <= '0;
      ifid_pc4 <= '0;
      idex     <= '0;
      exmem    <= '0;
      memwb    <= '0;
    end else begin
      // A stall freezes PC and IF/ID and suppresses any redirect this cycle
      if (!stall) begin
        pc       <= take ? target : pc + WIDTH'(4);
        ifid_ins <= take ? '0 : ins_i;
        ifid_pc4 <= pc + WIDTH'(4);
      end
      idex <= stall ? '0 : id_next;

      exmem.reg_write <= idex.ctrl.reg_write;
      exmem.mem_read  <= idex.ctrl.mem_read;
      exmem.mem_write <= idex.ctrl.mem_write;
      exmem.dest      <= idex.dest;
      exmem.alu       <= alu_res;
      exmem.st_data   <= fwd_b;

      memwb.reg_write <= exmem.reg_write;
      memwb.mem_read  <= exmem.mem_read;
      memwb.dest      <= exmem.dest;
      memwb.alu       <= exmem.alu;
      memwb.load      <= data_from_mem_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wb_we) begin
      regs[memwb.dest] <= wb_val;
    end
  end

  assign pc_o             = pc;
  assign MEM_ctrl_o       = {exmem.mem_write, exmem.mem_read};
  assign mem_write_addr_o = exmem.alu;
  assign mem_write_data_o = exmem.st_data;

endmodule

// File: tb/tb_mips_cpu.sv
// Scoreboard bench for mips_cpu: directed programs with external instruction/data memories;
// every MEM-stage access is popped from an expectation queue and compared (kind, address, data, cycle).
module tb_mips_cpu;

`ifdef MIPS_CPU_FORWARD_EN
  localparam int FWD = 1;
`else
  localparam int FWD = 0;
`endif

  localparam logic [5:0] ADDI = 6'h08;
  localparam logic [5:0] LW   = 6'h23;
  localparam logic [5:0] SW   = 6'h2B;
  localparam logic [5:0] BEQ  = 6'h04;
  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2A;
  localparam logic [1:0] RD = 2'b01;
  localparam logic [1:0] WR = 2'b10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] ins;
  logic [31:0] rdata;
  logic [31:0] pc;
  logic [1:0]  mem_ctrl;
  logic [31:0] addr;
  logic [31:0] wdata;

  logic [31:0] imem      [64];
  logic [31:0] dmem      [64];
  logic [31:0] dmem_init [64];

  int checks = 0;
  int fails  = 0;
  int cyc;

  typedef struct {
    string       name;
    logic [1:0]  ctrl;
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t q[$];

  mips_cpu #(.WIDTH(32)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .ins_i            (ins),
    .data_from_mem_i  (rdata),
    .pc_o             (pc),
    .MEM_ctrl_o       (mem_ctrl),
    .mem_write_addr_o (addr),
    .mem_write_data_o (wdata)
  );

  always #5 clk = ~clk;

  assign ins   = imem[pc[7:2]];
  assign rdata = dmem[addr[7:2]];

  always @(posedge clk) begin
    if (rst) dmem <= dmem_init;
    else if (mem_ctrl[1]) dmem[addr[7:2]] <= wdata;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  function automatic logic [31:0] r_ins(int rs, int rt, int rd, logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction

  function automatic logic [31:0] i_ins(logic [5:0] op, int rs, int rt, int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic logic [31:0] j_ins(int tgt);
    return {6'h02, 26'(tgt)};
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic expect_op(string nm, logic [1:0] c, logic [31:0] a, logic [31:0] d, int cy);
    exp_t e;
    e.name = nm;
    e.ctrl = c;
    e.addr = a;
    e.data = d;
    e.cyc  = cy;
    q.push_back(e);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && mem_ctrl != 2'b00) begin
        checks++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_mem_op actual ctrl=%b addr=%h data=%h cyc=%0d required none",
                   mem_ctrl, addr, wdata, cyc);
        end else begin
          e = q.pop_front();
          if (mem_ctrl !== e.ctrl || addr !== e.addr || (e.ctrl[1] && wdata !== e.data) ||
              (e.cyc >= 0 && cyc != e.cyc)) begin
            fails++;
            $display("FAIL %s actual ctrl=%b addr=%h data=%h cyc=%0d required ctrl=%b addr=%h data=%h cyc=%0d",
                     e.name, mem_ctrl, addr, wdata, cyc, e.ctrl, e.addr, e.data, e.cyc);
          end
        end
      end
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) begin
      imem[i]      = '0;
      dmem_init[i] = '0;
    end
  endtask

  // Assert reset mid-cycle while the previous program runs; outputs must clear at once
  task automatic async_reset(string nm);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk({nm, "_rst_pc"},   pc, 32'd0);
    chk({nm, "_rst_ctrl"}, {30'd0, mem_ctrl}, 32'd0);
    chk({nm, "_rst_addr"}, addr, 32'd0);
    chk({nm, "_rst_data"}, wdata, 32'd0);
  endtask

  // Release reset, run for a bounded number of cycles, then require every expectation consumed
  task automatic run(string nm, int ncyc);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (ncyc) @(negedge clk);
    #1;
    chk({nm, "_pending"}, 32'(q.size()), 32'd0);
    q.delete();
    async_reset(nm);
  endtask

  initial begin
    fork
      monitor();
    join_none

    // Reset hold, then sequential fetch through NOPs
    clear_mem();
    repeat (3) begin
      @(negedge clk);
      chk("hold_pc", pc, 32'd0);
      chk("hold_ctrl", {30'd0, mem_ctrl}, 32'd0);
    end
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1 chk("pc_seq", pc, 32'(4 * k));
      @(negedge clk);
    end
    async_reset("nop");

    // A: double data hazard, ALU ops, signed slt, wrap-around, r0, unsupported opcode
    clear_mem();
    imem[0]  = i_ins(ADDI, 0, 1, 1);
    imem[1]  = r_ins(1, 1, 1, F_ADD);
    imem[2]  = r_ins(1, 1, 1, F_ADD);
    imem[3]  = i_ins(SW, 0, 1, 'h40);
    imem[4]  = i_ins(ADDI, 0, 2, -3);
    imem[5]  = r_ins(1, 2, 3, F_SUB);
    imem[6]  = r_ins(2, 1, 4, F_SLT);
    imem[7]  = r_ins(1, 2, 5, F_SLT);
    imem[8]  = r_ins(2, 3, 6, F_AND);
    imem[9]  = r_ins(2, 3, 7, F_OR);
    imem[10] = r_ins(7, 3, 9, F_ADD);
    imem[11] = 32'h3C01_1234;
    imem[12] = i_ins(ADDI, 0, 0, 5);
    imem[13] = r_ins(0, 0, 10, F_ADD);
    imem[14] = i_ins(SW, 0, 3, 'h44);
    imem[15] = i_ins(SW, 0, 4, 'h48);
    imem[16] = i_ins(SW, 0, 5, 'h4C);
    imem[17] = i_ins(SW, 0, 6, 'h50);
    imem[18] = i_ins(SW, 0, 7, 'h54);
    imem[19] = i_ins(SW, 0, 9, 'h58);
    imem[20] = i_ins(SW, 0, 1, 'h5C);
    imem[21] = i_ins(SW, 0, 10, 'h60);
    imem[22] = i_ins(SW, 1, 3, -4);
    imem[23] = j_ins(23);
    expect_op("dbl_hazard_r1", WR, 32'h40, 32'd4, FWD ? 6 : 12);
    expect_op("sub_r3",        WR, 32'h44, 32'd7, -1);
    expect_op("slt_neg_lt",    WR, 32'h48, 32'd1, -1);
    expect_op("slt_pos_ge",    WR, 32'h4C, 32'd0, -1);
    expect_op("and_r6",        WR, 32'h50, 32'd5, -1);
    expect_op("or_r7",         WR, 32'h54, 32'hFFFF_FFFF, -1);
    expect_op("add_wrap",      WR, 32'h58, 32'd6, -1);
    expect_op("nop_opcode",    WR, 32'h5C, 32'd4, -1);
    expect_op("r0_write",      WR, 32'h60, 32'd0, -1);
    expect_op("sw_neg_off",    WR, 32'h00, 32'd7, -1);
    run("alu", 100);

    // B: load-use
    clear_mem();
    dmem_init[0] = 32'd7;
    imem[0] = i_ins(LW, 0, 5, 0);
    imem[1] = r_ins(5, 5, 5, F_ADD);
    imem[2] = i_ins(SW, 0, 5, 'h40);
    imem[3] = j_ins(3);
    expect_op("ld_use_lw", RD, 32'h00, 32'd0, 3);
    expect_op("ld_use_sw", WR, 32'h40, 32'd14, FWD ? 6 : 9);
    run("ld_use", 40);

    // C: load then branch, taken, fall-through slot flushed
    clear_mem();
    dmem_init[0] = 32'd7;
    imem[0] = i_ins(LW, 0, 5, 0);
    imem[1] = i_ins(BEQ, 5, 5, 1);
    imem[2] = i_ins(SW, 0, 5, 'h40);
    imem[3] = i_ins(SW, 0, 5, 'h44);
    imem[4] = j_ins(4);
    expect_op("ld_br_lw", RD, 32'h00, 32'd0, 3);
    expect_op("ld_br_sw", WR, 32'h44, 32'd7, 8);
    run("ld_br", 40);

    // D: branch after ALU op (taken), branch not taken, jump with flush
    clear_mem();
    imem[0] = i_ins(ADDI, 0, 1, 5);
    imem[1] = i_ins(ADDI, 0, 2, 5);
    imem[2] = i_ins(BEQ, 1, 2, 2);
    imem[3] = i_ins(SW, 0, 1, 'h40);
    imem[4] = i_ins(SW, 0, 1, 'h44);
    imem[5] = i_ins(BEQ, 1, 0, 5);
    imem[6] = j_ins(9);
    imem[7] = i_ins(SW, 0, 1, 'h48);
    imem[8] = i_ins(SW, 0, 1, 'h4C);
    imem[9] = i_ins(SW, 0, 2, 'h50);
    imem[10] = j_ins(10);
    expect_op("br_jump_sw", WR, 32'h50, 32'd5, FWD ? 11 : 12);
    run("br_j", 40);

    // E: summation loop over four data words with a backward jump
    clear_mem();
    dmem_init[0] = 32'd10;
    dmem_init[1] = 32'hFFFF_FFFD;
    dmem_init[2] = 32'd25;
    dmem_init[3] = 32'd100;
    imem[0] = i_ins(ADDI, 0, 1, 0);
    imem[1] = i_ins(ADDI, 0, 2, 16);
    imem[2] = i_ins(ADDI, 0, 16, 0);
    imem[3] = i_ins(LW, 1, 3, 0);
    imem[4] = r_ins(16, 3, 16, F_ADD);
    imem[5] = i_ins(ADDI, 1, 1, 4);
    imem[6] = i_ins(BEQ, 1, 2, 1);
    imem[7] = j_ins(3);
    imem[8] = i_ins(SW, 0, 16, 'h40);
    imem[9] = j_ins(9);
    for (int k = 0; k < 4; k++) expect_op("loop_lw", RD, 32'(4 * k), 32'd0, -1);
    expect_op("loop_sum", WR, 32'h40, 32'd132, -1);
    run("loop", 150);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/mips_cpu.md
MIPS_CPU -- requirements
Module: mips_cpu

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-002 WIDTH, default 32, SHALL set the datapath, instruction and address width.
REQ-003 clk_i  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst_i  input  1  asynchronous active-high reset.
REQ-005 ins_i  input  WIDTH  instruction word fetched combinationally at pc_o.
REQ-006 data_from_mem_i  input  WIDTH  load data returned combinationally for mem_write_addr_o.
REQ-007 pc_o  output  WIDTH  byte address of the instruction in IF.
REQ-008 MEM_ctrl_o  output  2  {MemWrite, MemRead} of the instruction in MEM.
REQ-009 mem_write_addr_o  output  WIDTH  byte address (ALU result) of the MEM-stage access.
REQ-010 mem_write_data_o  output  WIDTH  store data of the MEM-stage sw.

Function
REQ-011 The block SHALL be a 5-stage in-order pipeline (IF, ID, EX, MEM, WB) with registers IF/ID, ID/EX, EX/MEM and MEM/WB.
REQ-012 Supported instructions SHALL be R-type add, sub, and, or, slt (funct 0x20/0x22/0x24/0x25/0x2A), addi (0x08), lw (0x23), sw (0x2B), beq (0x04) and j (0x02); any other opcode SHALL execute as a NOP.
REQ-013 Register file: 32x32; r0 reads 0 and ignores writes; a WB write SHALL be visible to an ID read in the same cycle.
REQ-014 Arithmetic SHALL be 32-bit two's complement with wrap-around and no overflow trap; slt SHALL be signed; the addi/lw/sw/beq immediate SHALL be sign-extended.
REQ-015 PC SHALL advance by 4 each unstalled cycle; the beq target SHALL be PC+4+(imm<<2); the j target SHALL be {PC+4[31:28], target26, 2'b00}.
REQ-016 beq SHALL be resolved in ID with an equality comparator; a taken beq or a j SHALL redirect the PC next cycle and flush IF/ID to a NOP (1-cycle penalty). Branches are predicted not-taken.
REQ-017 Forwarding SHALL feed each EX ALU operand from EX/MEM (priority) or MEM/WB when the source register matches a non-zero destination being written; the ID comparator SHALL be fed from EX/MEM.
REQ-018 Load-use: an instruction in ID that reads the rt of an lw in EX SHALL stall 1 cycle. PC and IF/ID hold; a bubble enters ID/EX.
REQ-019 Branch after ALU op: beq in ID whose source is written by the instruction in EX SHALL stall 1 cycle.
REQ-020 Branch after load: beq in ID whose source is written by an lw in EX SHALL stall 2 cycles; an lw in MEM SHALL stall 1 cycle.
REQ-021 MEM_ctrl_o, mem_write_addr_o and mem_write_data_o SHALL be driven directly from EX/MEM; mem_write_data_o SHALL carry the forwarded rt value.
REQ-022 Loads SHALL capture data_from_mem_i into MEM/WB at the end of MEM; the register write SHALL occur in WB.
REQ-023 A stall and a taken branch in the same cycle: the stall SHALL win and the branch SHALL re-evaluate next cycle.

Reset
REQ-024 While rst_i is high: pc_o = 0, all pipeline registers hold NOPs (all control bits 0), MEM_ctrl_o = 2'b00, mem_write_addr_o = 0, mem_write_data_o = 0, and all registers = 0.
REQ-025 Reset asserted mid-operation SHALL discard all in-flight instructions; fetch SHALL restart at address 0 on the first rising edge after release.

Configuration
REQ-026 With macro MIPS_CPU_FORWARD_EN defined, forwarding per REQ-017 and the stall rules REQ-018 to REQ-020 SHALL apply.
REQ-027 Without MIPS_CPU_FORWARD_EN, there SHALL be no forwarding: any consumer in ID SHALL stall until its producer reaches WB. Architectural results SHALL be identical; only the cycle counts differ.

Verification
REQ-028 Reset: hold rst_i high, then release -> pc_o = 0, then 4, 8, 12 on successive edges; MEM_ctrl_o = 00 throughout reset.
REQ-029 Double data hazard: addi r1,r0,1; add r1,r1,r1; add r1,r1,r1 -> r1 = 4 with no stall.
REQ-030 Load-use: memory word 0 = 7; lw r5,0(r0); add r5,r5,r5 -> exactly 1 stall cycle; r5 = 14.
REQ-031 Load-branch: lw r5,0(r0) (=7); beq r5,r5,+1 -> 2 stall cycles, then taken, with the next sequential instruction flushed.
REQ-032 Bubble sort and checksum program with external word memories, run 8000 ns after reset -> data words 20..25 ascending (signed) and r16 = 12833; the same result with and without MIPS_CPU_FORWARD_EN.
